// File: rtl/gshare_pht.sv
// Purpose : gshare pattern history table; XORs fetch PC with global history to pick a 2-bit counter.
// Latency : 1 cycle from fetch_valid to registered pred_*; single update port writes on the same edge.
// Backpres: stall freezes pred_* (lookup result dropped), table updates and statistics still proceed.
//
// Ports:
//   clock, reset            - rising-edge clock, asynchronous active-low reset
//   stall                   - hold registered prediction outputs
//   fetch_valid/pc, ghr     - lookup request, fetch PC and registered global history
//   pred_valid/taken/index  - registered prediction and the index it came from
//   upd_valid/index/taken   - resolved-branch counter training
//   upd_mispredict          - statistics only, feeds mispredict_count
//   mispredict_count        - saturating 16-bit count of mispredicted updates

module gshare_pht #(
    parameter int         GHR_W     = 6,
    parameter int         PC_W      = 32,
    parameter int         IDX_W     = 6,
    parameter logic [1:0] CNT_RESET = 2'b01
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             fetch_valid,
    input  logic [PC_W-1:0]  fetch_pc,
    input  logic [GHR_W-1:0] ghr_fetch,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_index,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_index,
    input  logic             upd_taken,
    input  logic             upd_mispredict,
    output logic [15:0]      mispredict_count
);

    localparam int DEPTH = 1 << IDX_W;

    // Registered prediction bundle.
    typedef struct packed {
        logic             vld;
        logic             taken;
        logic [IDX_W-1:0] idx;
    } pred_t;

    logic [1:0]       cnt_q [DEPTH];
    pred_t            pred_q;
    pred_t            pred_d;
    logic [15:0]      mis_cnt_q;
    logic [15:0]      mis_cnt_d;

    logic [IDX_W-1:0] lkp_idx;
    logic [1:0]       upd_old;
    logic [1:0]       upd_new;
    logic [1:0]       lkp_cnt;

    // Word-offset bits of the PC and anything above the index field do not
    // participate in the hash.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[PC_W-1:IDX_W+2], fetch_pc[1:0]};

    // History is zero-extended into the low bits of the index.
    assign lkp_idx = fetch_pc[IDX_W+1:2] ^ IDX_W'(ghr_fetch);

    // Saturating train of the entry addressed by the update port.
    always_comb begin
        upd_old = cnt_q[upd_index];
        upd_new = upd_old;
        if (upd_taken) begin
            if (upd_old != 2'b11) upd_new = upd_old + 2'd1;
        end else begin
            if (upd_old != 2'b00) upd_new = upd_old - 2'd1;
        end
    end

    // Write-before-read bypass: a lookup colliding with this cycle's update
    // observes the trained value rather than the stale stored one.
    always_comb begin
        if (upd_valid && (upd_index == lkp_idx)) lkp_cnt = upd_new;
        else                                     lkp_cnt = cnt_q[lkp_idx];
    end

    always_comb begin
        pred_d = pred_q;
        if (!stall) begin
            pred_d.vld = fetch_valid;
            if (fetch_valid) begin
                pred_d.taken = lkp_cnt[1];
                pred_d.idx   = lkp_idx;
            end
        end
    end

    always_comb begin
        mis_cnt_d = mis_cnt_q;
        if (upd_valid && upd_mispredict && (mis_cnt_q != 16'hFFFF))
            mis_cnt_d = mis_cnt_q + 16'd1;
    end

    // Table kept in flops so the asynchronous reset clears every entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_RESET;
        end else if (upd_valid) begin
            cnt_q[upd_index] <= upd_new;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pred_q    <= '0;
            mis_cnt_q <= '0;
        end else begin
            pred_q    <= pred_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign pred_valid       = pred_q.vld;
    assign pred_taken       = pred_q.taken;
    assign pred_index       = pred_q.idx;
    assign mispredict_count = mis_cnt_q;

endmodule
